instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Programming-side counterpart of the processor's opcode-to-control decoder: converts instruction requests (op class plus register, immediate and shift fields) into 32-bit LEGv8 machine words.
- Writes each word into instruction memory through a held-request write port, at sequential word addresses.
- Used by the self-loading testbench/boot path to build programs in instruction memory before the core is released from reset.

Parameters:
- BASE_ADDR, 0, byte address of the first word written.
- ADDR_W, 64, width of imem_addr.
- DEPTH, 64, maximum number of words per program.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous restart pulse for a new program.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid & in_ready.
- in_op  in  4  0 AND, 1 ORR, 2 ADD, 3 SUB, 4 ADDI, 5 SUBI, 6 MOVZ, 7 B, 8 CBZ, 9 LDUR, 10 STUR; 11-15 illegal.
- in_rd  in  5  Rd, or Rt for CBZ/LDUR/STUR.
- in_rn  in  5  Rn.
- in_rm  in  5  Rm.
- in_imm  in  26  immediate, two's complement where signed.
- in_hw  in  2  MOVZ shift field.
- in_last  in  1  marks the final request of a program.
- imem_we  out  1  write request.
- imem_addr  out  ADDR_W  byte address.
- imem_wdata  out  32  encoded word.
- imem_ack  in  1  memory accepted the write this cycle.
- word_count  out  7  words written since reset/clr.
- done  out  1  program complete.
- err  out  1  sticky error flag.

Behaviour:
- Reset (async): state IDLE, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, word_count=0, done=0, err=0.
- Encodings, fields packed MSB to LSB:
  - R-type (AND 10001010000, ORR 10101010000, ADD 10001011000, SUB 11001011000): op11 | Rm | shamt=000000 | Rn | Rd.
  - I-type (ADDI 1001000100, SUBI 1101000100): op10 | imm[11:0] | Rn | Rd.
  - MOVZ: 110100101 | hw | imm[15:0] | Rd.
  - B: 000101 | imm[25:0].
  - CBZ: 10110100 | imm[18:0] | Rt.
  - LDUR 11111000010 / STUR 11111000000: op11 | imm[8:0] | 00 | Rn | Rt.
  - Immediate bits above the field width are ignored; no range check.
- FSM states: IDLE, WRITE, DONE.
- IDLE:
  - in_ready = (word_count < DEPTH).
  - Accept of a legal op: register the word into imem_wdata, go to WRITE next cycle. Latency from accept to imem_we is 1 cycle.
  - Accept of an illegal op: err<=1, no write. If in_last is set, go to DONE; otherwise stay in IDLE.
- WRITE:
  - in_ready=0; imem_we=1, with imem_addr and imem_wdata held stable until imem_ack.
  - On ack: imem_addr+=4, word_count+=1, imem_we deasserts the next cycle. Go to DONE if the registered last flag is set, else IDLE.
  - An ack in the same cycle imem_we first asserts counts as an ack.
- DONE: in_ready=0, done=1. Hold until clr or reset.
- Full: when word_count==DEPTH in IDLE, in_ready=0. If in_valid is seen in this condition, err<=1 and the request is not consumed.
- clr, in any state: next cycle is IDLE with imem_addr=BASE_ADDR, word_count=0, done=0, err=0, imem_we=0. clr aborts an unacked write in WRITE; the word is dropped.
- imem_ack outside WRITE is ignored.
- Reset mid-write drops imem_we asynchronously.

Test Plan:
- ADD X3,X1,X2 (op2, rd3, rn1, rm2), ack after 2 cycles -> imem_we held 2 cycles, imem_wdata=0x8B020023, imem_addr=BASE_ADDR, then imem_addr=BASE_ADDR+4, word_count=1.
- Back-to-back LDUR X9,[X22,#8] then MOVZ X9,#0x1234,LSL16 (hw1, in_last), immediate ack -> words 0xF84082C9 then 0xD2A24689 at +0 and +4; done=1; in_ready=0 afterwards.
- B imm=-3 (in_imm=0x3FFFFFD) and CBZ X0,#2 -> 0x17FFFFFD and 0xB4000040.
- Illegal op 12 with in_last=0 -> err=1, no imem_we, word_count unchanged, next legal request still written.
- Fill DEPTH words -> in_ready=0; extra in_valid sets err=1. clr -> word_count=0, imem_addr=BASE_ADDR, err=0.
- Assert reset while imem_we=1 and no ack -> imem_we=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/instr_encoder.sv
// Builds LEGv8 machine words from instruction requests and writes them into
// instruction memory at sequential word addresses through a held-request port.
module instr_encoder #(
    parameter int unsigned         ADDR_W    = 64,
    parameter logic [ADDR_W-1:0]   BASE_ADDR = '0,
    parameter int unsigned         DEPTH     = 64
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [25:0]       in_imm,
    input  logic [1:0]        in_hw,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    input  logic              imem_ack,
    output logic [6:0]        word_count,
    output logic              done,
    output logic              err
);

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_ORR  = 4'd1;
    localparam logic [3:0] OP_ADD  = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_ADDI = 4'd4;
    localparam logic [3:0] OP_SUBI = 4'd5;
    localparam logic [3:0] OP_MOVZ = 4'd6;
    localparam logic [3:0] OP_B    = 4'd7;
    localparam logic [3:0] OP_CBZ  = 4'd8;
    localparam logic [3:0] OP_LDUR = 4'd9;
    localparam logic [3:0] OP_STUR = 4'd10;

    localparam logic [6:0] DEPTH_C = 7'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rn;
        logic [4:0]  rm;
        logic [25:0] imm;
        logic [1:0]  hw;
        logic        last;
    } enc_req_t;

    state_t   state, state_d;
    enc_req_t req;
    logic     last_q;
    logic     accept;
    logic     enc_legal;
    logic [31:0] enc_word;

    assign req = '{op: in_op, rd: in_rd, rn: in_rn, rm: in_rm,
                   imm: in_imm, hw: in_hw, last: in_last};

    assign in_ready = (state == S_IDLE) && (word_count < DEPTH_C);
    assign imem_we  = (state == S_WRITE);
    assign done     = (state == S_DONE);
    assign accept   = in_valid && in_ready;

    // Field packing; immediate bits above each field width are simply dropped.
    always_comb begin
        enc_legal = 1'b1;
        enc_word  = '0;
        case (req.op)
            OP_AND:  enc_word = {11'b10001010000, req.rm, 6'b000000, req.rn, req.rd};
            OP_ORR:  enc_word = {11'b10101010000, req.rm, 6'b000000, req.rn, req.rd};
            OP_ADD:  enc_word = {11'b10001011000, req.rm, 6'b000000, req.rn, req.rd};
            OP_SUB:  enc_word = {11'b11001011000, req.rm, 6'b000000, req.rn, req.rd};
            OP_ADDI: enc_word = {10'b1001000100, req.imm[11:0], req.rn, req.rd};
            OP_SUBI: enc_word = {10'b1101000100, req.imm[11:0], req.rn, req.rd};
            OP_MOVZ: enc_word = {9'b110100101, req.hw, req.imm[15:0], req.rd};
            OP_B:    enc_word = {6'b000101, req.imm[25:0]};
            OP_CBZ:  enc_word = {8'b10110100, req.imm[18:0], req.rd};
            OP_LDUR: enc_word = {11'b11111000010, req.imm[8:0], 2'b00, req.rn, req.rd};
            OP_STUR: enc_word = {11'b11111000000, req.imm[8:0], 2'b00, req.rn, req.rd};
            default: enc_legal = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (enc_legal)    state_d = S_WRITE;
                    else if (req.last) state_d = S_DONE;
                end
            end
            S_WRITE: begin
                if (imem_ack) state_d = last_q ? S_DONE : S_IDLE;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        // clr wins everywhere, including aborting an unacked write.
        if (clr) state_d = S_IDLE;
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            imem_addr  <= BASE_ADDR;
            imem_wdata <= '0;
            word_count <= '0;
            err        <= 1'b0;
            last_q     <= 1'b0;
        end else if (clr) begin
            imem_addr  <= BASE_ADDR;
            word_count <= '0;
            err        <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (enc_legal) begin
                            imem_wdata <= enc_word;
                            last_q     <= req.last;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (in_valid) begin
                        // Only reachable when full: request refused, not consumed.
                        err <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (imem_ack) begin
                        imem_addr  <= imem_addr + ADDR_W'(4);
                        word_count <= word_count + 7'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
